audio_sdram_port: RTL and testbench
===================================

AUDIO_SDRAM_PORT -- requirements
Module: audio_sdram_port

Interface
REQ-001 SHALL have parameter ADDR_W, default 23: SDRAM word-address width.
REQ-002 SHALL have parameter BASE_ADDR, default 0: first word address of the audio region.
REQ-003 SHALL have parameter MAX_WORDS, default 23'h400000: capacity of the audio region in 32-bit words.
REQ-004 SHALL have port i_clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have ports i_start_rec, i_start_play and i_stop, each input, 1: single-cycle command pulses.
REQ-007 SHALL have ports i_sample_in (input, 16) and i_sample_valid (input, 1): record sample stream.
REQ-008 SHALL have ports o_sample_out (output, 16), o_sample_valid (output, 1) and i_sample_ready (input, 1): playback stream.
REQ-009 SHALL have port sdram_addr, output, ADDR_W: word address to the SDRAM bus core.
REQ-010 SHALL have ports sdram_read, sdram_write and sdram_finished, each 1: read and write are outputs; finished is an input.
REQ-011 SHALL have ports sdram_readdata (input, 32) and sdram_writedata (output, 32).
REQ-012 SHALL have ports o_busy (output, 1), o_overrun (output, 1), o_rec_len (output, ADDR_W) and o_state (output, 3, debug).

Function
REQ-013 SHALL implement states IDLE, REC_FILL, REC_WR, PLAY_RD and PLAY_OUT; o_busy is high in every state except IDLE.
REQ-014 SHALL, in IDLE, go to REC_FILL on i_start_rec and clear the write pointer to 0.
REQ-015 SHALL, in IDLE, go to PLAY_RD on i_start_play when o_rec_len is not 0; when o_rec_len is 0, the command is ignored.
REQ-016 SHALL give recording priority when i_start_rec and i_start_play arrive together; start pulses outside IDLE are ignored.
REQ-017 SHALL pack samples big-half-first: the first valid sample goes to writedata[31:16] and the second to [15:0]; after the second sample the block moves to REC_WR.
REQ-018 SHALL drive sdram_write and sdram_read from registers and hold them, with a stable sdram_addr = BASE_ADDR + pointer, until the cycle sdram_finished is seen.
REQ-019 SHALL deassert the request on the clock edge after sdram_finished, so no request is held for two finished cycles.
REQ-020 SHALL, on write finish, increment the write pointer, set o_rec_len to the pointer, and return to REC_FILL.
REQ-021 SHALL drop any sample with i_sample_valid high during REC_WR and pulse o_overrun for 1 cycle.
REQ-022 SHALL stop recording when the write pointer reaches MAX_WORDS, returning to IDLE with o_rec_len = MAX_WORDS.
REQ-023 SHALL handle i_stop in REC_FILL with one sample pending by writing the word with [15:0] = 0, then going to IDLE; with no sample pending it goes to IDLE directly.
REQ-024 SHALL, on i_stop in REC_WR or PLAY_RD, complete the outstanding SDRAM access and then go to IDLE.
REQ-025 SHALL, in PLAY_RD, latch sdram_readdata on sdram_finished and go to PLAY_OUT.
REQ-026 SHALL, in PLAY_OUT, present [31:16] and then [15:0] with o_sample_valid high; each half advances only when i_sample_ready is high.
REQ-027 SHALL, after the low half is accepted, increment the read pointer; if pointer == o_rec_len it applies end-of-data behaviour (REQ-030/031), else it returns to PLAY_RD.
REQ-028 SHALL, on i_stop in PLAY_OUT, go to IDLE at the next edge and drop o_sample_valid.

Reset
REQ-029 SHALL, on i_rst, at the next edge return to IDLE and clear to 0 sdram_read, sdram_write, sdram_addr, sdram_writedata, o_sample_out, o_sample_valid, o_overrun, o_busy, o_rec_len, both pointers and the half-select, including mid-access.

Configuration
REQ-030 SHALL, with AUDIO_PORT_LOOP_EN defined, reset the read pointer to 0 at end of data and continue in PLAY_RD until i_stop.
REQ-031 SHALL, without AUDIO_PORT_LOOP_EN, go to IDLE at end of data.

Structure
REQ-032 SHALL put the state enum, the 16-bit sample width and the default ADDR_W in shared package audio_sdram_pkg.
REQ-033 SHALL put the PLAY_OUT half-select and valid/ready logic in sub-module sample_unpacker; all other logic stays in audio_sdram_port.

Verification
REQ-034 SHALL cover: rec 4 samples 0x1111, 0x2222, 0x3333, 0x4444, then stop -> writes 0x11112222 @0 and 0x33334444 @1; o_rec_len = 2.
REQ-035 SHALL cover: rec 3 samples, then stop -> second write 0x33330000 @1; o_rec_len = 2.
REQ-036 SHALL cover: finished delayed 5 cycles -> sdram_write held 5 cycles with stable addr; a sample during this window -> o_overrun pulses once and the sample is not written.
REQ-037 SHALL cover: play rec_len = 2 with i_sample_ready toggling -> output 0x1111, 0x2222, 0x3333, 0x4444 in order; IDLE without the macro, 0x1111 repeats with it.
REQ-038 SHALL cover: i_start_play with rec_len = 0 -> stays IDLE; simultaneous rec and play starts -> REC_FILL.
REQ-039 SHALL cover: i_rst during PLAY_RD -> next cycle sdram_read = 0, o_rec_len = 0, o_state = IDLE.

Source files
------------

// File: rtl/audio_sdram_pkg.sv
// Shared types and constants for the audio SDRAM record/playback port.
// Holds the controller state enum, sample width and default address width.
package audio_sdram_pkg;

    localparam int AUDIO_SAMPLE_W = 16;
    localparam int AUDIO_WORD_W   = 2 * AUDIO_SAMPLE_W;
    localparam int AUDIO_ADDR_W   = 23;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REC_FILL = 3'd1,
        S_REC_WR   = 3'd2,
        S_PLAY_RD  = 3'd3,
        S_PLAY_OUT = 3'd4
    } state_e;

endpackage

// File: rtl/sample_unpacker.sv
// Splits a 32-bit word into two samples, high half first, on valid/ready.
// Ports: i_load/i_word load a word, i_clear drops it, i_ready accepts,
// o_sample/o_valid present a half, o_done pulses when the low half is taken.
module sample_unpacker
    import audio_sdram_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_load,
    input  logic [AUDIO_WORD_W-1:0]   i_word,
    input  logic                      i_clear,
    input  logic                      i_ready,
    output logic [AUDIO_SAMPLE_W-1:0] o_sample,
    output logic                      o_valid,
    output logic                      o_done
);

    logic [AUDIO_WORD_W-1:0] word_q, word_d;
    logic                    half_q, half_d;
    logic                    valid_q, valid_d;

    assign o_done = valid_q & half_q & i_ready;

    always_comb begin
        word_d  = word_q;
        half_d  = half_q;
        valid_d = valid_q;
        if (i_clear) begin
            valid_d = 1'b0;
            half_d  = 1'b0;
        end else if (i_load) begin
            word_d  = i_word;
            half_d  = 1'b0;
            valid_d = 1'b1;
        end else if (valid_q && i_ready) begin
            if (!half_q) begin
                half_d = 1'b1;
            end else begin
                half_d  = 1'b0;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            word_q  <= '0;
            half_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            half_q  <= half_d;
            valid_q <= valid_d;
        end
    end

    assign o_sample = half_q ? word_q[AUDIO_SAMPLE_W-1:0]
                             : word_q[AUDIO_WORD_W-1:AUDIO_SAMPLE_W];
    assign o_valid  = valid_q;

endmodule

// File: rtl/audio_sdram_port.sv
// Records 16-bit samples into SDRAM packed two per word and plays them back.
// Ports: command pulses, record/playback streams, SDRAM req/finished bus,
// status (busy, overrun, recorded length, debug state).
// Build option AUDIO_PORT_LOOP_EN: playback wraps to word 0 instead of ending.
module audio_sdram_port
    import audio_sdram_pkg::*;
#(
    parameter int                ADDR_W    = AUDIO_ADDR_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [ADDR_W-1:0] MAX_WORDS = 23'h400000
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start_rec,
    input  logic                      i_start_play,
    input  logic                      i_stop,
    input  logic [AUDIO_SAMPLE_W-1:0] i_sample_in,
    input  logic                      i_sample_valid,
    output logic [AUDIO_SAMPLE_W-1:0] o_sample_out,
    output logic                      o_sample_valid,
    input  logic                      i_sample_ready,
    output logic [ADDR_W-1:0]         sdram_addr,
    output logic                      sdram_read,
    output logic                      sdram_write,
    input  logic                      sdram_finished,
    input  logic [AUDIO_WORD_W-1:0]   sdram_readdata,
    output logic [AUDIO_WORD_W-1:0]   sdram_writedata,
    output logic                      o_busy,
    output logic                      o_overrun,
    output logic [ADDR_W-1:0]         o_rec_len,
    output logic [2:0]                o_state
);

    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]       rec_len_q, rec_len_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [AUDIO_WORD_W-1:0] wdata_q, wdata_d;
    logic                    half_q, half_d;
    logic                    read_q, read_d;
    logic                    write_q, write_d;
    logic                    overrun_q, overrun_d;
    logic                    stop_q, stop_d;
    logic                    unp_load, unp_clear, unp_done;
    logic [ADDR_W-1:0]       wr_next, rd_next;

    assign wr_next = wr_ptr_q + PTR_ONE;
    assign rd_next = rd_ptr_q + PTR_ONE;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rec_len_d = rec_len_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        half_d    = half_q;
        read_d    = read_q;
        write_d   = write_q;
        overrun_d = 1'b0;
        stop_d    = stop_q;
        unp_load  = 1'b0;
        unp_clear = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                stop_d = 1'b0;
                if (i_start_rec) begin
                    state_d  = S_REC_FILL;
                    wr_ptr_d = '0;
                    half_d   = 1'b0;
                end else if (i_start_play && rec_len_q != '0) begin
                    state_d  = S_PLAY_RD;
                    rd_ptr_d = '0;
                    read_d   = 1'b1;
                    addr_d   = BASE_ADDR;
                end
            end
            S_REC_FILL: begin
                if (i_stop) begin
                    if (half_q) begin
                        // Flush the lone pending sample with a zero low half.
                        wdata_d[AUDIO_SAMPLE_W-1:0] = '0;
                        half_d  = 1'b0;
                        write_d = 1'b1;
                        addr_d  = BASE_ADDR + wr_ptr_q;
                        stop_d  = 1'b1;
                        state_d = S_REC_WR;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (i_sample_valid) begin
                    if (!half_q) begin
                        wdata_d[AUDIO_WORD_W-1:AUDIO_SAMPLE_W] = i_sample_in;
                        half_d = 1'b1;
                    end else begin
                        wdata_d[AUDIO_SAMPLE_W-1:0] = i_sample_in;
                        half_d  = 1'b0;
                        write_d = 1'b1;
                        addr_d  = BASE_ADDR + wr_ptr_q;
                        state_d = S_REC_WR;
                    end
                end
            end
            S_REC_WR: begin
                overrun_d = i_sample_valid;
                if (i_stop) stop_d = 1'b1;
                if (sdram_finished) begin
                    write_d   = 1'b0;
                    wr_ptr_d  = wr_next;
                    rec_len_d = wr_next;
                    if (stop_q || i_stop || wr_next == MAX_WORDS) begin
                        stop_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_REC_FILL;
                    end
                end
            end
            S_PLAY_RD: begin
                if (i_stop) stop_d = 1'b1;
                if (sdram_finished) begin
                    read_d = 1'b0;
                    if (stop_q || i_stop) begin
                        stop_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        unp_load = 1'b1;
                        state_d  = S_PLAY_OUT;
                    end
                end
            end
            S_PLAY_OUT: begin
                if (i_stop) begin
                    unp_clear = 1'b1;
                    state_d   = S_IDLE;
                end else if (unp_done) begin
                    if (rd_next == rec_len_q) begin
`ifdef AUDIO_PORT_LOOP_EN
                        rd_ptr_d = '0;
                        read_d   = 1'b1;
                        addr_d   = BASE_ADDR;
                        state_d  = S_PLAY_RD;
`else
                        rd_ptr_d = rd_next;
                        state_d  = S_IDLE;
`endif
                    end else begin
                        rd_ptr_d = rd_next;
                        read_d   = 1'b1;
                        addr_d   = BASE_ADDR + rd_next;
                        state_d  = S_PLAY_RD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rec_len_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            half_q    <= 1'b0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            overrun_q <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rec_len_q <= rec_len_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            half_q    <= half_d;
            read_q    <= read_d;
            write_q   <= write_d;
            overrun_q <= overrun_d;
            stop_q    <= stop_d;
        end
    end

    sample_unpacker u_unpacker (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (unp_load),
        .i_word   (sdram_readdata),
        .i_clear  (unp_clear),
        .i_ready  (i_sample_ready),
        .o_sample (o_sample_out),
        .o_valid  (o_sample_valid),
        .o_done   (unp_done)
    );

    assign sdram_addr      = addr_q;
    assign sdram_read      = read_q;
    assign sdram_write     = write_q;
    assign sdram_writedata = wdata_q;
    assign o_busy          = (state_q != S_IDLE);
    assign o_overrun       = overrun_q;
    assign o_rec_len       = rec_len_q;
    assign o_state         = state_q;

endmodule

// File: tb/tb_audio_sdram_port.sv
// Self-checking bench for audio_sdram_port with a small SDRAM responder.
// Expected writes and playback samples are queued and compared on arrival.
module tb_audio_sdram_port;
    import audio_sdram_pkg::*;

    typedef struct {
        logic [22:0] addr;
        logic [31:0] data;
        int          hold;
        bit          stable;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        i_start_rec, i_start_play, i_stop;
    logic [15:0] i_sample_in;
    logic        i_sample_valid;
    logic [15:0] o_sample_out;
    logic        o_sample_valid;
    logic        i_sample_ready;
    logic [22:0] sdram_addr;
    logic        sdram_read, sdram_write, sdram_finished;
    logic [31:0] sdram_readdata, sdram_writedata;
    logic        o_busy, o_overrun;
    logic [22:0] o_rec_len;
    logic [2:0]  o_state;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          resp_delay = 1;
    int          overrun_cnt = 0;
    logic [31:0] mem [0:15];
    wr_t         obs_wr[$];
    wr_t         exp_wr[$];
    logic [15:0] obs_play[$];
    logic [15:0] exp_play[$];

    audio_sdram_port dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start_rec    (i_start_rec),
        .i_start_play   (i_start_play),
        .i_stop         (i_stop),
        .i_sample_in    (i_sample_in),
        .i_sample_valid (i_sample_valid),
        .o_sample_out   (o_sample_out),
        .o_sample_valid (o_sample_valid),
        .i_sample_ready (i_sample_ready),
        .sdram_addr     (sdram_addr),
        .sdram_read     (sdram_read),
        .sdram_write    (sdram_write),
        .sdram_finished (sdram_finished),
        .sdram_readdata (sdram_readdata),
        .sdram_writedata(sdram_writedata),
        .o_busy         (o_busy),
        .o_overrun      (o_overrun),
        .o_rec_len      (o_rec_len),
        .o_state        (o_state)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // SDRAM responder: finished after resp_delay request cycles
    initial begin
        int          cnt;
        logic [22:0] req_addr;
        bit          stable;
        cnt = 0;
        stable = 1;
        req_addr = '0;
        sdram_finished = 0;
        sdram_readdata = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        forever begin
            @(negedge clk);
            if (sdram_finished) begin
                sdram_finished = 0;
                cnt = 0;
            end else if (rst || !(sdram_write || sdram_read)) begin
                cnt = 0;
            end else begin
                if (cnt == 0) begin
                    req_addr = sdram_addr;
                    stable = 1;
                end else if (sdram_addr !== req_addr) begin
                    stable = 0;
                end
                cnt++;
                if (cnt >= resp_delay) begin
                    sdram_finished = 1;
                    if (sdram_write) begin
                        mem[sdram_addr[3:0]] = sdram_writedata;
                        obs_wr.push_back('{sdram_addr, sdram_writedata,
                                           cnt, stable});
                    end else begin
                        sdram_readdata = mem[sdram_addr[3:0]];
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (o_sample_valid && i_sample_ready)
                obs_play.push_back(o_sample_out);
            if (o_overrun) overrun_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        int n = 0;
        while (o_state !== s && n < 300) begin
            tick();
            n++;
        end
        if (o_state !== s) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: state=%0d want=%0d", tag, o_state, s);
        end
    endtask

    task automatic pulse_start(input bit rec, input bit play);
        i_start_rec = rec;
        i_start_play = play;
        tick();
        i_start_rec = 0;
        i_start_play = 0;
    endtask

    task automatic pulse_stop();
        i_stop = 1;
        tick();
        i_stop = 0;
    endtask

    task automatic send_sample(input logic [15:0] v);
        wait_state(S_REC_FILL, "send_sample");
        i_sample_in = v;
        i_sample_valid = 1;
        tick();
        i_sample_valid = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) tick();
        rst = 0;
        tick();
        n_tests++;
        if (o_state !== S_IDLE || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d busy=%b want 0/0",
                     o_state, o_busy);
        end
        n_tests++;
        if (sdram_read !== 0 || sdram_write !== 0 || sdram_addr !== 0 ||
            sdram_writedata !== 0) begin
            n_fail++;
            $display("FAIL reset_bus: rd=%b wr=%b addr=%h wd=%h want 0",
                     sdram_read, sdram_write, sdram_addr, sdram_writedata);
        end
        n_tests++;
        if (o_rec_len !== 0 || o_sample_valid !== 0 || o_overrun !== 0 ||
            o_sample_out !== 0) begin
            n_fail++;
            $display("FAIL reset_status: len=%0d sv=%b ov=%b so=%h want 0",
                     o_rec_len, o_sample_valid, o_overrun, o_sample_out);
        end
    endtask

    task automatic test_play_empty();
        pulse_start(0, 1);
        n_tests++;
        if (o_state !== S_IDLE || sdram_read !== 0) begin
            n_fail++;
            $display("FAIL play_empty: state=%0d rd=%b want 0/0",
                     o_state, sdram_read);
        end
    endtask

    task automatic test_rec_three();
        obs_wr.delete();
        exp_wr.delete();
        exp_wr.push_back('{23'd0, 32'h11112222, 1, 1});
        exp_wr.push_back('{23'd1, 32'h33330000, 1, 1});
        pulse_start(1, 0);
        send_sample(16'h1111);
        send_sample(16'h2222);
        send_sample(16'h3333);
        pulse_stop();
        wait_state(S_IDLE, "rec3_idle");
        n_tests++;
        if (obs_wr.size() != exp_wr.size()) begin
            n_fail++;
            $display("FAIL rec3_count: got %0d writes want %0d",
                     obs_wr.size(), exp_wr.size());
        end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            wr_t e = exp_wr.pop_front();
            wr_t o = obs_wr.pop_front();
            n_tests++;
            if (o.addr !== e.addr || o.data !== e.data) begin
                n_fail++;
                $display("FAIL rec3_write: got %h@%0d want %h@%0d",
                         o.data, o.addr, e.data, e.addr);
            end
        end
        n_tests++;
        if (o_rec_len !== 23'd2) begin
            n_fail++;
            $display("FAIL rec3_len: got %0d want 2", o_rec_len);
        end
    endtask

    task automatic test_rec_four();
        obs_wr.delete();
        exp_wr.delete();
        exp_wr.push_back('{23'd0, 32'h11112222, 1, 1});
        exp_wr.push_back('{23'd1, 32'h33334444, 1, 1});
        pulse_start(1, 0);
        send_sample(16'h1111);
        send_sample(16'h2222);
        send_sample(16'h3333);
        send_sample(16'h4444);
        wait_state(S_REC_FILL, "rec4_fill");
        pulse_stop();
        wait_state(S_IDLE, "rec4_idle");
        n_tests++;
        if (obs_wr.size() != exp_wr.size()) begin
            n_fail++;
            $display("FAIL rec4_count: got %0d writes want %0d",
                     obs_wr.size(), exp_wr.size());
        end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            wr_t e = exp_wr.pop_front();
            wr_t o = obs_wr.pop_front();
            n_tests++;
            if (o.addr !== e.addr || o.data !== e.data) begin
                n_fail++;
                $display("FAIL rec4_write: got %h@%0d want %h@%0d",
                         o.data, o.addr, e.data, e.addr);
            end
        end
        n_tests++;
        if (o_rec_len !== 23'd2) begin
            n_fail++;
            $display("FAIL rec4_len: got %0d want 2", o_rec_len);
        end
    endtask

    task automatic test_play();
        int n = 0;
        int need;
        obs_play.delete();
        exp_play.delete();
        exp_play.push_back(16'h1111);
        exp_play.push_back(16'h2222);
        exp_play.push_back(16'h3333);
        exp_play.push_back(16'h4444);
`ifdef AUDIO_PORT_LOOP_EN
        exp_play.push_back(16'h1111);
`endif
        need = exp_play.size();
        i_sample_ready = 0;
        pulse_start(0, 1);
        while (obs_play.size() < need && n < 400) begin
            i_sample_ready = ~i_sample_ready;
            tick();
            n++;
        end
        i_sample_ready = 0;
        n_tests++;
        if (obs_play.size() < need) begin
            n_fail++;
            $display("FAIL play_count: got %0d samples want %0d",
                     obs_play.size(), need);
        end
        while (exp_play.size() > 0 && obs_play.size() > 0) begin
            logic [15:0] e = exp_play.pop_front();
            logic [15:0] o = obs_play.pop_front();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL play_sample: got %h want %h", o, e);
            end
        end
`ifdef AUDIO_PORT_LOOP_EN
        n_tests++;
        if (o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL play_loop_busy: busy=%b want 1", o_busy);
        end
        pulse_stop();
        wait_state(S_IDLE, "play_stop");
`else
        tick();
        n_tests++;
        if (o_state !== S_IDLE) begin
            n_fail++;
            $display("FAIL play_end: state=%0d want %0d", o_state, S_IDLE);
        end
`endif
        n_tests++;
        if (o_sample_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL play_valid_drop: valid=%b want 0", o_sample_valid);
        end
    endtask

    task automatic test_simultaneous();
        pulse_start(1, 1);
        n_tests++;
        if (o_state !== S_REC_FILL || sdram_read !== 0) begin
            n_fail++;
            $display("FAIL simul_start: state=%0d rd=%b want %0d/0",
                     o_state, sdram_read, S_REC_FILL);
        end
        pulse_stop();
        wait_state(S_IDLE, "simul_idle");
    endtask

    task automatic test_overrun_delay();
        obs_wr.delete();
        overrun_cnt = 0;
        resp_delay = 5;
        pulse_start(1, 0);
        send_sample(16'h5555);
        send_sample(16'h6666);
        i_sample_in = 16'hDEAD;
        i_sample_valid = 1;
        tick();
        i_sample_valid = 0;
        wait_state(S_REC_FILL, "ovr_fill");
        pulse_stop();
        wait_state(S_IDLE, "ovr_idle");
        resp_delay = 1;
        n_tests++;
        if (obs_wr.size() != 1) begin
            n_fail++;
            $display("FAIL ovr_count: got %0d writes want 1", obs_wr.size());
        end
        if (obs_wr.size() > 0) begin
            wr_t o = obs_wr.pop_front();
            n_tests++;
            if (o.addr !== 23'd0 || o.data !== 32'h55556666) begin
                n_fail++;
                $display("FAIL ovr_write: got %h@%0d want 55556666@0",
                         o.data, o.addr);
            end
            n_tests++;
            if (o.hold != 5 || !o.stable) begin
                n_fail++;
                $display("FAIL ovr_hold: got hold=%0d stable=%0d want 5/1",
                         o.hold, o.stable);
            end
        end
        n_tests++;
        if (overrun_cnt != 1) begin
            n_fail++;
            $display("FAIL ovr_pulse: got %0d cycles want 1", overrun_cnt);
        end
        n_tests++;
        if (o_rec_len !== 23'd1) begin
            n_fail++;
            $display("FAIL ovr_len: got %0d want 1", o_rec_len);
        end
    endtask

    task automatic test_reset_play_rd();
        resp_delay = 20;
        pulse_start(0, 1);
        tick();
        n_tests++;
        if (o_state !== S_PLAY_RD || sdram_read !== 1'b1) begin
            n_fail++;
            $display("FAIL rstrd_pre: state=%0d rd=%b want %0d/1",
                     o_state, sdram_read, S_PLAY_RD);
        end
        rst = 1;
        tick();
        n_tests++;
        if (sdram_read !== 0 || o_rec_len !== 0 || o_state !== S_IDLE) begin
            n_fail++;
            $display("FAIL rstrd_post: rd=%b len=%0d state=%0d want 0/0/0",
                     sdram_read, o_rec_len, o_state);
        end
        rst = 0;
        resp_delay = 1;
        repeat (2) tick();
    endtask

    initial begin
        rst = 1;
        i_start_rec = 0;
        i_start_play = 0;
        i_stop = 0;
        i_sample_in = '0;
        i_sample_valid = 0;
        i_sample_ready = 0;
        test_reset();
        test_play_empty();
        test_rec_three();
        test_rec_four();
        test_play();
        test_simultaneous();
        test_overrun_delay();
        test_reset_play_rd();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
